// File: rtl/angle_output_arbiter.sv
// Round-robin arbiter that serialises roll/pitch/yaw angle results into
// 5-byte frames (header, ID, data high, data low, checksum) over a byte transmitter.
module angle_output_arbiter #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter logic [7:0] ROLL_ID     = 8'h01,
  parameter logic [7:0] PITCH_ID    = 8'h02,
  parameter logic [7:0] YAW_ID      = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        roll_req,
  input  logic [15:0] roll_data,
  input  logic        pitch_req,
  input  logic [15:0] pitch_data,
  input  logic        yaw_req,
  input  logic [15:0] yaw_data,
  output logic        roll_ack,
  output logic        pitch_ack,
  output logic        yaw_ack,
  input  logic        tx_busy,
  output logic        tx_load,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_HOLD, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_ROLL, G_PITCH, G_YAW} grant_t;

  state_t      r_state, w_state_nxt;
  grant_t      r_last_grant, w_last_nxt, w_gnt;
  logic        w_gnt_vld;
  logic [15:0] w_gnt_data;
  logic [7:0]  w_gnt_id;
  logic [15:0] r_data;
  logic [7:0]  r_id;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [2:0]  r_ack, w_ack_nxt;
  logic        r_tx_load, w_tx_load_nxt;
  logic [7:0]  r_tx_byte, w_tx_byte_nxt;
  logic        r_frame_done, w_done_nxt;
  logic [7:0]  r_frame_count, w_count_nxt;
  logic        w_capture;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] id,
                                            input logic [15:0] data);
    case (idx)
      3'd0:    frame_byte = HEADER_BYTE;
      3'd1:    frame_byte = id;
      3'd2:    frame_byte = data[15:8];
      3'd3:    frame_byte = data[7:0];
      default: frame_byte = id ^ data[15:8] ^ data[7:0];
    endcase
  endfunction

  // Search starts with the producer after the last one granted.
  always_comb begin
    w_gnt     = G_ROLL;
    w_gnt_vld = roll_req | pitch_req | yaw_req;
    case (r_last_grant)
      G_ROLL: begin
        if (pitch_req)     w_gnt = G_PITCH;
        else if (yaw_req)  w_gnt = G_YAW;
        else               w_gnt = G_ROLL;
      end
      G_PITCH: begin
        if (yaw_req)       w_gnt = G_YAW;
        else if (roll_req) w_gnt = G_ROLL;
        else               w_gnt = G_PITCH;
      end
      default: begin
        if (roll_req)       w_gnt = G_ROLL;
        else if (pitch_req) w_gnt = G_PITCH;
        else                w_gnt = G_YAW;
      end
    endcase
  end

  always_comb begin
    w_gnt_data = roll_data;
    w_gnt_id   = ROLL_ID;
    case (w_gnt)
      G_PITCH: begin w_gnt_data = pitch_data; w_gnt_id = PITCH_ID; end
      G_YAW:   begin w_gnt_data = yaw_data;   w_gnt_id = YAW_ID;   end
      default: begin w_gnt_data = roll_data;  w_gnt_id = ROLL_ID;  end
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last_grant;
    w_idx_nxt     = r_idx;
    w_ack_nxt     = 3'b000;
    w_tx_load_nxt = 1'b0;
    w_tx_byte_nxt = r_tx_byte;
    w_done_nxt    = 1'b0;
    w_count_nxt   = r_frame_count;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_capture   = 1'b1;
          w_last_nxt  = w_gnt;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_SEND;
          case (w_gnt)
            G_PITCH: w_ack_nxt = 3'b010;
            G_YAW:   w_ack_nxt = 3'b100;
            default: w_ack_nxt = 3'b001;
          endcase
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_tx_load_nxt = 1'b1;
          w_tx_byte_nxt = frame_byte(r_idx, r_id, r_data);
          w_state_nxt   = S_HOLD;
        end
      end
      // Transmitter has not raised busy yet during the load cycle.
      S_HOLD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) begin
          if (r_idx == 3'd4) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_count_nxt = r_frame_count + 8'd1;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = S_SEND;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= G_YAW;
      r_idx         <= 3'd0;
      r_ack         <= 3'b000;
      r_tx_load     <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_frame_done  <= 1'b0;
      r_frame_count <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_nxt;
      r_idx         <= w_idx_nxt;
      r_ack         <= w_ack_nxt;
      r_tx_load     <= w_tx_load_nxt;
      r_tx_byte     <= w_tx_byte_nxt;
      r_frame_done  <= w_done_nxt;
      r_frame_count <= w_count_nxt;
    end
  end

  // Captured frame payload is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_data <= w_gnt_data;
      r_id   <= w_gnt_id;
    end
  end

  assign roll_ack    = r_ack[0];
  assign pitch_ack   = r_ack[1];
  assign yaw_ack     = r_ack[2];
  assign tx_load     = r_tx_load;
  assign tx_byte     = r_tx_byte;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_angle_output_arbiter.sv
// Directed bench for angle_output_arbiter with a cycle-stepped transmitter model.
module tb_angle_output_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        roll_req = 1'b0, pitch_req = 1'b0, yaw_req = 1'b0;
  logic [15:0] roll_data = 16'h0, pitch_data = 16'h0, yaw_data = 16'h0;
  logic        roll_ack, pitch_ack, yaw_ack;
  logic        tx_busy = 1'b0;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        busy, frame_done;
  logic [7:0]  frame_count;

  angle_output_arbiter dut (
    .clk(clk), .rst(rst),
    .roll_req(roll_req), .roll_data(roll_data),
    .pitch_req(pitch_req), .pitch_data(pitch_data),
    .yaw_req(yaw_req), .yaw_data(yaw_data),
    .roll_ack(roll_ack), .pitch_ack(pitch_ack), .yaw_ack(yaw_ack),
    .tx_busy(tx_busy), .tx_load(tx_load), .tx_byte(tx_byte),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] bytes[$];
  logic [7:0] fc_log[$];
  int ndone = 0, ack_cyc = 0, viol = 0;
  int busy_len = 3, cnt = 0;
  logic force_busy = 1'b0, load_prev = 1'b0, auto_drop = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT, then update the transmitter model and producers.
  task automatic tick();
    @(posedge clk); #1;
    if (tx_load && !load_prev && tx_busy) viol++;
    if (tx_load) bytes.push_back(tx_byte);
    if (roll_ack)  begin ack_cyc++; if (auto_drop) roll_req = 1'b0;  end
    if (pitch_ack) begin ack_cyc++; if (auto_drop) pitch_req = 1'b0; end
    if (yaw_ack)   begin ack_cyc++; if (auto_drop) yaw_req = 1'b0;   end
    if (frame_done) begin ndone++; fc_log.push_back(frame_count); end
    if (load_prev) cnt = busy_len;
    tx_busy = force_busy || (cnt != 0);
    if (cnt != 0) cnt--;
    load_prev = tx_load;
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt = 0; force_busy = 1'b0; tx_busy = 1'b0;
    tick(); tick();
    rst = 1'b0; load_prev = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (ndone < target && n < budget) begin tick(); n++; end
    if (ndone < target) check({tag, "_timeout"}, ndone, target);
  endtask

  task automatic wait_loads(input int target, input int budget, input string tag);
    int n = 0;
    while (bytes.size() < target && n < budget) begin tick(); n++; end
    if (bytes.size() < target) check({tag, "_timeout"}, bytes.size(), target);
  endtask

  task automatic check_frame(input string tag, input int b, input logic [7:0] id,
                             input logic [15:0] d);
    check({tag, "_hdr"}, bytes[b],   8'hA5);
    check({tag, "_id"},  bytes[b+1], id);
    check({tag, "_dh"},  bytes[b+2], d[15:8]);
    check({tag, "_dl"},  bytes[b+3], d[7:0]);
    check({tag, "_cs"},  bytes[b+4], id ^ d[15:8] ^ d[7:0]);
  endtask

  initial begin
    int b, d0, a0;
    // Reset state
    rst = 1'b1; tick(); tick();
    check("rst_tx_load", tx_load, 0);
    check("rst_acks", {roll_ack, pitch_ack, yaw_ack}, 0);
    check("rst_busy", busy, 0);
    check("rst_fc", frame_count, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;

    // Single roll frame, transmitter busy 3 cycles per byte
    b = bytes.size(); a0 = ack_cyc; d0 = ndone;
    roll_data = 16'h1234; roll_req = 1'b1;
    tick();
    check("t1_ack_pulse", roll_ack, 1);
    tick();
    check("t1_ack_low", roll_ack, 0);
    wait_done(d0 + 1, 200, "t1");
    tick(); tick(); tick();
    check("t1_nloads", bytes.size() - b, 5);
    check_frame("t1", b, 8'h01, 16'h1234);
    check("t1_cs_27", bytes[b+4], 8'h27);
    check("t1_acks", ack_cyc - a0, 1);
    check("t1_done", ndone - d0, 1);
    check("t1_fc", frame_count, 1);
    check("t1_busy", busy, 0);

    // Round-robin ordering
    do_reset();
    roll_data = 16'h0102; pitch_data = 16'h0304; yaw_data = 16'hFFFF;
    b = bytes.size(); d0 = ndone;
    roll_req = 1'b1; pitch_req = 1'b1; yaw_req = 1'b1;
    wait_done(d0 + 3, 400, "rr3");
    tick(); tick();
    check("rr3_id0", bytes[b+1], 8'h01);
    check("rr3_id1", bytes[b+6], 8'h02);
    check("rr3_id2", bytes[b+11], 8'h03);
    check_frame("yawFFFF", b + 10, 8'h03, 16'hFFFF);
    check("yawFFFF_cs03", bytes[b+14], 8'h03);

    b = bytes.size(); d0 = ndone;
    roll_req = 1'b1; yaw_req = 1'b1;
    wait_done(d0 + 2, 300, "ry");
    tick(); tick();
    check("ry_first", bytes[b+1], 8'h01);
    check("ry_second", bytes[b+6], 8'h03);

    d0 = ndone; roll_req = 1'b1;
    wait_done(d0 + 1, 200, "r1");
    tick(); tick();
    b = bytes.size(); d0 = ndone;
    pitch_req = 1'b1; yaw_req = 1'b1;
    wait_done(d0 + 2, 300, "py");
    tick(); tick();
    check("py_first", bytes[b+1], 8'h02);
    check("py_second", bytes[b+6], 8'h03);
    check("rr_fc", frame_count, 8);

    // Transmitter stalls
    b = bytes.size(); d0 = ndone; viol = 0;
    force_busy = 1'b1; tx_busy = 1'b1;
    roll_data = 16'hBEEF; roll_req = 1'b1;
    repeat (50) tick();
    check("stall_pre_loads", bytes.size() - b, 0);
    check("stall_pre_busy", busy, 1);
    force_busy = 1'b0;
    wait_loads(b + 2, 200, "stall_mid");
    force_busy = 1'b1;
    repeat (20) tick();
    check("stall_mid_loads", bytes.size() - b, 2);
    force_busy = 1'b0;
    wait_done(d0 + 1, 300, "stall");
    tick(); tick();
    check("stall_nloads", bytes.size() - b, 5);
    check_frame("stall", b, 8'h01, 16'hBEEF);
    check("stall_viol", viol, 0);
    check("stall_fc", frame_count, 9);

    // Reset in WAIT after the second byte
    b = bytes.size();
    roll_data = 16'h5555; roll_req = 1'b1;
    wait_loads(b + 2, 200, "rstmid");
    tick();
    rst = 1'b1; cnt = 0; tx_busy = 1'b0;
    tick();
    check("rstmid_tx_load", tx_load, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_acks", {roll_ack, pitch_ack, yaw_ack}, 0);
    check("rstmid_fc", frame_count, 0);
    rst = 1'b0; load_prev = 1'b0;
    b = bytes.size(); d0 = ndone;
    pitch_req = 1'b1; yaw_req = 1'b1;
    wait_done(d0 + 2, 300, "postrst");
    tick(); tick();
    check("postrst_nloads", bytes.size() - b, 10);
    check_frame("postrst_p", b, 8'h02, 16'h0304);
    check("postrst_second", bytes[b+6], 8'h03);
    check("postrst_fc", frame_count, 2);

    // 257 back-to-back roll frames: counter wrap
    do_reset();
    busy_len = 1; auto_drop = 1'b0; d0 = ndone;
    fc_log.delete();
    roll_data = 16'h0A0B; roll_req = 1'b1;
    wait_done(d0 + 257, 257 * 40, "wrap");
    roll_req = 1'b0;
    tick(); tick();
    check("wrap_ndone", ndone - d0, 257);
    if (fc_log.size() >= 257) begin
      check("wrap_fc255", fc_log[254], 8'd255);
      check("wrap_fc0",   fc_log[255], 8'd0);
      check("wrap_fc1",   fc_log[256], 8'd1);
    end else begin
      check("wrap_log_size", fc_log.size(), 257);
    end
    check("wrap_fc_final", frame_count, 1);
    check("wrap_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
